// File: rtl/nt_fir_shift_param.sv
// -----------------------------------------------------------------------------
// nt_fir_shift_param
//
// Purpose:
//   Parametrised shift-and-add FIR for the delta-sigma noise-transfer path.
//     y[n] = sum_{k=1..TAPS} s_k * (x[n-k] << sh_k)
//   Two coefficient banks are selectable at run time through `mode`:
//     bank 0 (default) : 2z^-1 -  z^-2   (ideal H1)
//     bank 1 (default) : 2z^-1 - 4z^-2   (imperfect H1)
//   The current sample never contributes, so the minimum delay is z^-1.
//   The output is registered.
//
// Configuration macro:
//   NT_FIR_SAT_EN  - when defined, an out-of-range result saturates to the
//                    WIDTH-bit signed limits. When undefined, it wraps
//                    (two's complement). The ovf pulse is the same in both
//                    builds.
//
// Ports:
//   CLK        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in         in   WIDTH  sample x[n], signed
//   in_valid   in   1      sample accept strobe
//   mode       in   1      coefficient bank select (0 = bank 0, 1 = bank 1)
//   clear      in   1      synchronous flush of delay line and output
//   out        out  WIDTH  y[n], registered, signed
//   out_valid  out  1      one-cycle pulse: out was updated
//   ovf        out  1      one-cycle pulse with out_valid: y did not fit WIDTH
// -----------------------------------------------------------------------------
module nt_fir_shift_param #(
    parameter int                   WIDTH  = 16,
    parameter int                   TAPS   = 2,
    parameter logic [4*TAPS-1:0]    SHIFT0 = 'h01,
    parameter logic [TAPS-1:0]      SIGN0  = 'b10,
    parameter logic [4*TAPS-1:0]    SHIFT1 = 'h21,
    parameter logic [TAPS-1:0]      SIGN1  = 'b10,
    parameter logic [TAPS-1:0]      MASK0  = '1,
    parameter logic [TAPS-1:0]      MASK1  = '1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic                    clear,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid,
    output logic                    ovf
);

    // Internal width: 7 bits of headroom for the largest shift, clog2(TAPS)
    // bits of growth for the adder tree and one more bit for subtraction.
    localparam int IW = WIDTH + 7 + $clog2(TAPS) + 1;

    // Delay line: d_q[k-1] holds x[n-k].
    logic signed [WIDTH-1:0] d_q [TAPS];

    logic signed [WIDTH-1:0] out_q;
    logic                    out_valid_q;
    logic                    ovf_q;

    // Per-tap weighted terms and their sum.
    logic signed [IW-1:0]    term [TAPS];
    logic signed [IW-1:0]    y_full;
    logic                    y_ovf;
    logic signed [WIDTH-1:0] y_fit;

    // -------------------------------------------------------------------------
    // Per-tap term generation. The bank is chosen here so that only the
    // selected coefficients reach the adder.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            logic [3:0]           sh;
            logic                 sub;
            logic                 en;
            logic signed [IW-1:0] ext;
            logic signed [IW-1:0] shifted;

            always_comb begin
                sh      = mode ? SHIFT1[4*gi +: 4] : SHIFT0[4*gi +: 4];
                sub     = mode ? SIGN1[gi]         : SIGN0[gi];
                en      = mode ? MASK1[gi]         : MASK0[gi];
                ext     = {{(IW-WIDTH){d_q[gi][WIDTH-1]}}, d_q[gi]};
                shifted = ext <<< sh;
                if (!en) begin
                    term[gi] = '0;
                end else if (sub) begin
                    term[gi] = -shifted;
                end else begin
                    term[gi] = shifted;
                end
            end
        end
    endgenerate

    always_comb begin
        y_full = '0;
        for (int k = 0; k < TAPS; k++) begin
            y_full = y_full + term[k];
        end
    end

    // The result fits WIDTH exactly when every bit from the WIDTH-1 position
    // upward equals the sign bit.
    assign y_ovf = !((&y_full[IW-1:WIDTH-1]) || !(|y_full[IW-1:WIDTH-1]));

`ifdef NT_FIR_SAT_EN
    always_comb begin
        if (!y_ovf) begin
            y_fit = y_full[WIDTH-1:0];
        end else if (y_full[IW-1]) begin
            y_fit = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            y_fit = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign y_fit = y_full[WIDTH-1:0];
`endif

    // -------------------------------------------------------------------------
    // State update. Clear outranks a simultaneous accept; the sample offered
    // with clear is dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (in_valid) begin
            d_q[0] <= in;
            for (int k = 1; k < TAPS; k++) begin
                d_q[k] <= d_q[k-1];
            end
            out_q       <= y_fit;
            out_valid_q <= 1'b1;
            ovf_q       <= y_ovf;
        end else begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/nt_fir_shift_param.md
Name: nt_fir_shift_param

Overview:
- Parametrised shift-and-add FIR for the delta-sigma noise-transfer path: y[n] = sum over k=1..TAPS of s_k * (x[n-k] << sh_k).
- Two coefficient banks are built in, selected at run time by `mode`. Default bank 0 is the ideal H1, 2z^-1 - z^-2. Default bank 1 is the imperfect H1, 2z^-1 - 4z^-2.
- Adds sample-valid gating, a registered output, synchronous flush, and overflow detection.
- Sits between the quantiser error tap and the loop-filter summing node.

Parameters:
- WIDTH, 16, sample width, two's complement, for `in` and `out`.
- TAPS, 2, number of delay taps (1..8). Tap k uses x[n-k].
- SHIFT0, 8'h01, bank-0 shift amounts, 4 bits per tap. Tap k is in bits [4k-1:4k-4]. Range 0..7.
- SIGN0, 2'b10, bank-0 signs, 1 bit per tap. Tap k is bit k-1. 1 = subtract.
- SHIFT1, 8'h21, bank-1 shift amounts, same packing as SHIFT0.
- SIGN1, 2'b10, bank-1 signs, same packing as SIGN0.
- MASK0, all ones (TAPS bits), bank-0 tap enable. 0 = tap contributes 0.
- MASK1, all ones (TAPS bits), bank-1 tap enable. 0 = tap contributes 0.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  sample x[n], signed.
- in_valid  input  1  sample accept strobe, sampled on rising CLK.
- mode  input  1  coefficient bank select: 0 = bank 0, 1 = bank 1.
- clear  input  1  synchronous flush of delay line and output.
- out  output  WIDTH  y[n], registered, signed.
- out_valid  output  1  one-cycle pulse: `out` was updated this cycle.
- ovf  output  1  one-cycle pulse, aligned with out_valid: full-precision y[n] did not fit in WIDTH.

Behaviour:
- Reset (async, reset=1): all delay registers d[1..TAPS] = 0, out = 0, out_valid = 0, ovf = 0. Outputs stay at these values while reset is held.
- Accept edge (in_valid=1, clear=0):
  - Full-precision result y is computed from the pre-edge d[1..TAPS], i.e. from x[n-1]..x[n-TAPS], using the bank selected by `mode` at that edge.
  - out <= fit(y).
  - d[1] <= in, and d[k] <= d[k-1] for k = 2..TAPS.
  - out_valid <= 1 and ovf <= (y outside the WIDTH signed range).
- Latency: `out` is visible on the cycle after the accept edge. The current sample does not contribute; the minimum delay is z^-1.
- Idle edge (in_valid=0, clear=0): d and out hold; out_valid <= 0, ovf <= 0.
- Clear edge (clear=1): d <= 0, out <= 0, out_valid <= 0, ovf <= 0. Clear has priority over a simultaneous in_valid, and that sample is discarded.
- Mode switch:
  - Takes effect at the first accept edge that samples the new value.
  - No flush: history is shared between banks.
  - mode is ignored on non-accept edges.
- Arithmetic:
  - Each term is sign-extended to IW = WIDTH + 7 + clog2(TAPS) + 1 bits, shifted left by sh_k, then added or subtracted.
  - IW guarantees no internal overflow.
  - fit() without SAT_EN: keep the low WIDTH bits (two's-complement wrap).
- Masked-out taps still shift through the delay line.
- Reset asserted mid-stream wins immediately. The first accept after release sees zero history.

Optional Feature:
- Macro NT_FIR_SAT_EN.
- When defined, fit() saturates: y > 2^(WIDTH-1)-1 gives 0x7FFF, and y < -2^(WIDTH-1) gives 0x8000 (WIDTH=16). ovf still pulses.
- When undefined, fit() wraps. ovf behaviour is identical in both builds.

Test Plan:
- mode=1: accept 10, 20, 30, 5 on consecutive cycles -> out = 0x0000, 0x0014, 0x0000, 0xFFEC; out_valid high 4 cycles; ovf 0.
- mode=0: same stream -> out = 0, 20, 30 (0x001E), 40 (0x0028).
- mode=1, no SAT: accept 32767 three times -> out = 0, 0xFFFE (ovf=1), 0x0002 (ovf=1). With NT_FIR_SAT_EN: out = 0, 0x7FFF, 0x8000, ovf=1 on the second and third results.
- mode=1, valid gaps: accept 10, idle 3 cycles, accept 20 -> out holds 0 with out_valid=0 during the gap, then out = 20 after accepting 20.
- clear asserted together with in_valid=1 and in=99 after history 10, 20 -> out = 0, out_valid = 0; next accept of 7 gives out = 0.
- Async reset mid-stream (no CLK edge needed) -> out = 0 immediately; after release, accept 50 then 60 (mode=1) -> out = 0, then 100 (0x0064).
